// File: rtl/gated_adder_reg.sv
// gated_adder_reg: registered WIDTH-bit adder with load enable.
// Each rising clk edge with s=1 captures (x + y) mod 2^WIDTH into r.
// With s=0 the result register holds; rst (synchronous, active-high) clears r
// and overrides s.
// Build option GATED_CLOCK_EN: the result flops run on a clock gated by an
// integrated clock-gate (low-transparent latch + AND) instead of using a
// feedback enable mux. r is cycle-identical in both builds.
module gated_adder_reg #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             s,
   input  logic             clk,
   output logic [WIDTH-1:0] r,
   input  logic             rst
);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_d;

   // Modulo-2^WIDTH sum; the carry-out is dropped by the WIDTH-wide result.
   always_comb begin
      sum = x + y;
   end

`ifdef GATED_CLOCK_EN
   logic gate_en;
   logic gate_en_q;
   logic gclk;

   // Reset must reach the flops, so it also opens the gate.
   always_comb begin
      gate_en = s | rst;
   end

   // Clock-gate latch: transparent while clk is low, so the enable seen by the
   // AND is frozen for the whole high phase and the gated clock cannot glitch.
   always_latch begin
      if (!clk) begin
         gate_en_q = gate_en;
      end
   end

   assign gclk = clk & gate_en_q;

   // The gated clock only pulses when loading or resetting, so no enable mux.
   always_comb begin
      r_d = rst ? '0 : sum;
   end

   // Result register on the gated clock.
   always_ff @(posedge gclk) begin
      r_q <= r_d;
   end
`else
   // Next state: reset wins, then load, otherwise hold via feedback.
   always_comb begin
      r_d = r_q;
      if (rst) begin
         r_d = '0;
      end else if (s) begin
         r_d = sum;
      end
   end

   // Result register on the free-running clock.
   always_ff @(posedge clk) begin
      r_q <= r_d;
   end
`endif

   assign r = r_q;

endmodule

// File: tb/tb_gated_adder_reg.sv
// Directed self-checking bench for gated_adder_reg (WIDTH=4).
// Inputs change on the falling edge; r is sampled 1 ns after the rising edge.
module tb_gated_adder_reg;

   logic       clk;
   logic       rst;
   logic       s;
   logic [3:0] x;
   logic [3:0] y;
   logic [3:0] r;

   int unsigned checks;
   int unsigned errors;

   gated_adder_reg #(.WIDTH(4)) dut (
      .x  (x),
      .y  (y),
      .s  (s),
      .clk(clk),
      .r  (r),
      .rst(rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs mid-cycle, then step past the next rising edge.
   task automatic apply(input logic rr, input logic ss,
                        input logic [3:0] xx, input logic [3:0] yy);
      @(negedge clk);
      rst = rr;
      s   = ss;
      x   = xx;
      y   = yy;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 2; i++) begin
         apply(1'b1, 1'b1, 4'd5, 4'd6);
         checks++;
         if (r !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold%0d: r=%0d expected=0", i, r);
         end
      end
      apply(1'b0, 1'b1, 4'd5, 4'd6);
      checks++;
      if (r !== 4'd11) begin
         errors++;
         $display("FAIL reset_release: r=%0d expected=11", r);
      end
   endtask

   task automatic test_load;
      apply(1'b0, 1'b1, 4'd1, 4'd1);
      checks++;
      if (r !== 4'd2) begin
         errors++;
         $display("FAIL load_1p1: r=%0d expected=2", r);
      end
      apply(1'b0, 1'b1, 4'd1, 4'd3);
      checks++;
      if (r !== 4'd4) begin
         errors++;
         $display("FAIL load_1p3: r=%0d expected=4", r);
      end
   endtask

   task automatic test_hold;
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 1'b0, 4'd1, 4'd2);
         checks++;
         if (r !== 4'd4) begin
            errors++;
            $display("FAIL hold_a%0d: r=%0d expected=4", i, r);
         end
      end
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 1'b0, 4'd4, 4'd3);
         checks++;
         if (r !== 4'd4) begin
            errors++;
            $display("FAIL hold_b%0d: r=%0d expected=4", i, r);
         end
      end
      // s pulses high between edges but is low at the edge: no load.
      @(negedge clk);
      x = 4'd7;
      y = 4'd7;
      s = 1'b1;
      #1;
      s = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (r !== 4'd4) begin
         errors++;
         $display("FAIL hold_glitch: r=%0d expected=4", r);
      end
   endtask

   task automatic test_wrap;
      apply(1'b0, 1'b1, 4'd15, 4'd1);
      checks++;
      if (r !== 4'd0) begin
         errors++;
         $display("FAIL wrap_15p1: r=%0d expected=0", r);
      end
      apply(1'b0, 1'b1, 4'd15, 4'd15);
      checks++;
      if (r !== 4'd14) begin
         errors++;
         $display("FAIL wrap_15p15: r=%0d expected=14", r);
      end
   endtask

   task automatic test_reset_priority;
      apply(1'b0, 1'b1, 4'd4, 4'd5);
      checks++;
      if (r !== 4'd9) begin
         errors++;
         $display("FAIL prio_setup: r=%0d expected=9", r);
      end
      apply(1'b1, 1'b1, 4'd3, 4'd3);
      checks++;
      if (r !== 4'd0) begin
         errors++;
         $display("FAIL prio_rst_over_s: r=%0d expected=0", r);
      end
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 1'b0, 4'd3, 4'd3);
         checks++;
         if (r !== 4'd0) begin
            errors++;
            $display("FAIL prio_after%0d: r=%0d expected=0", i, r);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0] expected;
      logic [3:0] sum;
      logic       en;
      expected = 4'd0;
      for (int i = 0; i < 10; i++) begin
         sum = 4'(i + 2);
         en  = (i % 2 == 0);
         apply(1'b0, en, 4'd1, sum - 4'd1);
         if (en) expected = sum;
         checks++;
         if (r !== expected) begin
            errors++;
            $display("FAIL toggle%0d: r=%0d expected=%0d", i, r, expected);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      s   = 1'b0;
      x   = 4'd0;
      y   = 4'd0;
      test_reset;
      test_load;
      test_hold;
      test_wrap;
      test_reset_priority;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gated_adder_reg.md
# gated_adder_reg

Registered 4-bit adder with load enable, used as the reference datapath for the automatic clock-gating flow. Each rising clock edge with the select input high captures the modulo-2^WIDTH sum of the two operands. With select low, the result register holds its value. The register's enable can be implemented as a true gated clock, so the flow can compare a gated netlist against an enable-mux netlist.

## Interface
- WIDTH, default 4: operand and result width in bits.

Ports, in declaration order `x, y, s, clk, r, rst`:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous and active-high. It clears r and takes priority over s.
- x  input  WIDTH  addend A, unsigned.
- y  input  WIDTH  addend B, unsigned.
- s  input  1  load enable; 1 = capture x+y, 0 = hold.
- r  output  WIDTH  registered sum, driven directly from flops.

## Operation
- The sum is unsigned: x + y truncated to WIDTH bits. The carry-out is discarded, so the sum wraps (e.g. 15+1 -> 0 when WIDTH=4).
- At each rising clk edge:
  - rst=1: r <= 0, regardless of s, x and y.
  - rst=0, s=1: r <= (x + y) mod 2^WIDTH.
  - rst=0, s=0: r holds its previous value. Changes on x and y have no effect.
- There is no combinational path from x, y or s to r.
- The enable is level-sampled at the edge. Only the value of s at the edge matters; glitches between edges are ignored.
- The block has no state other than the WIDTH result flops, plus the gate latch when gating is enabled.

## Timing
- Latency: 1 cycle. Inputs set up before edge N appear on r immediately after edge N.
- Throughput: one new sum per cycle while s=1.
- Reset value of r: 0. The value of r after power-up and before the first reset edge is undefined.
- Asserting rst mid-operation clears r at the next edge. With s=1 and rst=1 together, r becomes 0.
- After rst is released with s=1, the first edge loads x+y.
- x, y and s must be stable around the rising edge. In the test plan, inputs change mid-cycle, away from clk rising edges.

## Configuration
- Macro: `GATED_CLOCK_EN`.
- Defined:
  - The result flops are clocked by a gated clock from an integrated clock-gate: a latch that is transparent while clk is low, followed by an AND with clk.
  - The gate enable is s | rst, so reset still reaches the flops.
  - The flops have no enable mux.
  - The gate output must be glitch-free: the enable can change only while clk is low.
- Undefined:
  - The flops run on free-running clk, with a feedback mux: r <= rst ? 0 : (s ? x+y : r).
- The behaviour at r must be cycle-identical in both builds. The same test plan must pass unchanged.

## Test plan
- Reset: rst=1 for 2 edges with x=5, y=6, s=1 -> r=0. Release rst with the same inputs -> r=11 after the next edge.
- Load: x=1, y=1, s=1, one edge -> r=2. Then x=1, y=3, s=1, one edge -> r=4.
- Hold: from r=4, set x=1, y=2, s=0 for 2 edges -> r stays 4. Then x=4, y=3, s=0 for 2 edges -> r stays 4.
- Wrap-around: x=15, y=1, s=1 -> r=0. Then x=15, y=15, s=1 -> r=14.
- Reset priority and mid-operation reset: from r=9, apply rst=1 with s=1, x=3, y=3 for one edge -> r=0. Then rst=0 and s=0 for 2 edges -> r stays 0.
- Enable toggling every cycle: alternate s=1 and s=0 while x+y increments through 2, 3, 4, and so on. r updates only on edges where s=1, with a 1-cycle lag. Run under both macro settings and compare waveforms of r; they must match exactly.
